// File: rtl/regs_fwd_scoreboard.sv
// Operand forwarding with youngest-match priority, plus a per-register
// pending-write scoreboard for long-latency producers.
// Operands resolve in the same cycle. The scoreboard updates on each clock edge.
module regs_fwd_scoreboard #(
  parameter int unsigned READ_PORTS  = 4,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [READ_PORTS*$clog2(REG_NUM)-1:0]         raddr_i,
  input  logic [READ_PORTS*32-1:0]                      rddata_i,
  input  logic [STAGES*WRITE_PORTS-1:0]                 fwd_we_i,
  input  logic [STAGES*WRITE_PORTS*$clog2(REG_NUM)-1:0] fwd_waddr_i,
  input  logic [STAGES*WRITE_PORTS*32-1:0]              fwd_wrdata_i,
  input  logic [STAGES*WRITE_PORTS-1:0]                 fwd_ready_i,
  input  logic [WRITE_PORTS-1:0]                        issue_we_i,
  input  logic [WRITE_PORTS*$clog2(REG_NUM)-1:0]        issue_waddr_i,
  input  logic [WRITE_PORTS-1:0]                        retire_we_i,
  input  logic [WRITE_PORTS*$clog2(REG_NUM)-1:0]        retire_waddr_i,
  input  logic                                          flush_i,
  output logic [READ_PORTS*32-1:0]                      rddata_o,
  output logic                                          stall_o,
  output logic                                          issue_ready_o,
  output logic                                          err_o,
  output logic [31:0]                                   stall_cnt_o
);

  localparam int unsigned AW = $clog2(REG_NUM);
  // Sum width: a full counter plus one increment per lane, with headroom.
  localparam int unsigned SW = CNT_WIDTH + $clog2(WRITE_PORTS + 1) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((32'd1 << CNT_WIDTH) - 32'd1);

  logic [CNT_WIDTH-1:0] pending_q [REG_NUM];
  logic [CNT_WIDTH-1:0] pending_d [REG_NUM];
  logic [SW-1:0]        inc_cnt   [REG_NUM];
  logic [SW-1:0]        ret_cnt   [REG_NUM];
  logic [SW-1:0]        post_ret  [REG_NUM];
  logic                 issue_ok;
  logic                 err_set;
  logic [READ_PORTS-1:0] fwd_wait;
  logic [READ_PORTS-1:0] pend_hit;
  logic                 err_q;
  logic [31:0]          stall_cnt_q;

  // Flat lane index of write port w in stage s.
  function automatic int unsigned lane_idx(input int unsigned s, input int unsigned w);
    return s * WRITE_PORTS + w;
  endfunction

  // Operand mux: scan oldest to youngest so the last match (youngest stage,
  // highest write port) wins, and its ready bit alone decides the hazard.
  always_comb begin
    rddata_o = '0;
    fwd_wait = '0;
    pend_hit = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rddata_o[p*32 +: 32] = rddata_i[p*32 +: 32];
      for (int unsigned k = 0; k < STAGES; k++) begin
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
          if (fwd_we_i[lane_idx(STAGES - 1 - k, w)] &&
              (fwd_waddr_i[lane_idx(STAGES - 1 - k, w)*AW +: AW] == raddr_i[p*AW +: AW])) begin
            rddata_o[p*32 +: 32] = fwd_wrdata_i[lane_idx(STAGES - 1 - k, w)*32 +: 32];
            fwd_wait[p]          = ~fwd_ready_i[lane_idx(STAGES - 1 - k, w)];
          end
        end
      end
      if (raddr_i[p*AW +: AW] == '0) begin
        rddata_o[p*32 +: 32] = '0;
        fwd_wait[p]          = 1'b0;
      end else begin
        pend_hit[p] = (pending_q[raddr_i[p*AW +: AW]] != '0);
      end
    end
  end

  // Stall is suppressed while reset is held so issue logic sees a clean pipe.
  always_comb begin
    stall_o = rst_n & ((|fwd_wait) | (|pend_hit));
  end

  // Per-register lane counts, post-retire occupancy and the all-or-nothing issue check.
  always_comb begin
    issue_ok = 1'b1;
    err_set  = 1'b0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      inc_cnt[r]  = '0;
      ret_cnt[r]  = '0;
      post_ret[r] = '0;
      for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
        if (issue_we_i[w] && (issue_waddr_i[w*AW +: AW] == AW'(r))) begin
          inc_cnt[r] = inc_cnt[r] + SW'(1);
        end
        if (retire_we_i[w] && (retire_waddr_i[w*AW +: AW] == AW'(r))) begin
          ret_cnt[r] = ret_cnt[r] + SW'(1);
        end
      end
      if (r == 0) begin
        inc_cnt[r] = '0;
        ret_cnt[r] = '0;
      end
      if (ret_cnt[r] > SW'(pending_q[r])) begin
        // Retire without a matching issue: clamp at zero and flag it.
        post_ret[r] = '0;
        err_set     = 1'b1;
      end else begin
        post_ret[r] = SW'(pending_q[r]) - ret_cnt[r];
      end
      if ((post_ret[r] + inc_cnt[r]) > CNT_MAX) begin
        issue_ok = 1'b0;
      end
    end
  end

  // Next pending counts; flush drops every in-flight entry and this cycle's traffic.
  always_comb begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      pending_d[r] = pending_q[r];
      if (flush_i || (r == 0)) begin
        pending_d[r] = '0;
      end else if (issue_ok) begin
        pending_d[r] = CNT_WIDTH'(post_ret[r] + inc_cnt[r]);
      end else begin
        pending_d[r] = CNT_WIDTH'(post_ret[r]);
      end
    end
  end

  // Issue acceptance is reported as always-ready while reset is held.
  always_comb begin
    issue_ready_o = ~rst_n | issue_ok;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        pending_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        pending_q[r] <= pending_d[r];
      end
    end
  end

  // Sticky underflow flag and the free-running stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q <= err_q | (err_set & ~flush_i);
      if (stall_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_regs_fwd_scoreboard.sv
// Directed bench for regs_fwd_scoreboard with a behavioural reference model.
`timescale 1ns/1ps
module tb_regs_fwd_scoreboard;

  localparam int RP   = 4;
  localparam int WP   = 2;
  localparam int ST   = 3;
  localparam int RN   = 32;
  localparam int CW   = 2;
  localparam int AW   = 5;
  localparam int NL   = ST * WP;
  localparam int MAXP = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RP*AW-1:0]  raddr_i;
  logic [RP*32-1:0]  rddata_i;
  logic [NL-1:0]     fwd_we_i;
  logic [NL*AW-1:0]  fwd_waddr_i;
  logic [NL*32-1:0]  fwd_wrdata_i;
  logic [NL-1:0]     fwd_ready_i;
  logic [WP-1:0]     issue_we_i;
  logic [WP*AW-1:0]  issue_waddr_i;
  logic [WP-1:0]     retire_we_i;
  logic [WP*AW-1:0]  retire_waddr_i;
  logic              flush_i;
  logic [RP*32-1:0]  rddata_o;
  logic              stall_o;
  logic              issue_ready_o;
  logic              err_o;
  logic [31:0]       stall_cnt_o;

  int          total = 0;
  int          bad   = 0;
  int          m_pend [RN];
  bit          m_err;
  logic [31:0] m_cnt;

  regs_fwd_scoreboard #(
    .READ_PORTS(RP), .WRITE_PORTS(WP), .STAGES(ST), .REG_NUM(RN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr_i), .rddata_i(rddata_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wrdata_i(fwd_wrdata_i),
    .fwd_ready_i(fwd_ready_i),
    .issue_we_i(issue_we_i), .issue_waddr_i(issue_waddr_i),
    .retire_we_i(retire_we_i), .retire_waddr_i(retire_waddr_i),
    .flush_i(flush_i),
    .rddata_o(rddata_o), .stall_o(stall_o), .issue_ready_o(issue_ready_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int r = 0; r < RN; r++) m_pend[r] = 0;
    m_err = 1'b0;
    m_cnt = 32'd0;
  endtask

  // Search youngest stage first, highest port first; first hit is the producer.
  function automatic logic [31:0] exp_rd(input int p);
    logic [AW-1:0] a;
    logic [31:0]   d;
    bit            found;
    a = raddr_i[p*AW +: AW];
    d = rddata_i[p*32 +: 32];
    found = 1'b0;
    for (int s = 0; s < ST; s++)
      for (int w = WP - 1; w >= 0; w--)
        if (!found && fwd_we_i[s*WP+w] && fwd_waddr_i[(s*WP+w)*AW +: AW] == a) begin
          found = 1'b1;
          d = fwd_wrdata_i[(s*WP+w)*32 +: 32];
        end
    if (a == 0) d = 32'd0;
    return d;
  endfunction

  function automatic bit exp_stall();
    logic [AW-1:0] a;
    bit            found;
    bit            st;
    st = 1'b0;
    for (int p = 0; p < RP; p++) begin
      a = raddr_i[p*AW +: AW];
      found = 1'b0;
      if (a != 0) begin
        for (int s = 0; s < ST; s++)
          for (int w = WP - 1; w >= 0; w--)
            if (!found && fwd_we_i[s*WP+w] && fwd_waddr_i[(s*WP+w)*AW +: AW] == a) begin
              found = 1'b1;
              if (!fwd_ready_i[s*WP+w]) st = 1'b1;
            end
        if (m_pend[a] != 0) st = 1'b1;
      end
    end
    return rst_n ? st : 1'b0;
  endfunction

  function automatic bit exp_ready();
    int            tmp [RN];
    logic [AW-1:0] a;
    bit            ok;
    ok = 1'b1;
    for (int r = 0; r < RN; r++) tmp[r] = m_pend[r];
    for (int w = 0; w < WP; w++) begin
      a = retire_waddr_i[w*AW +: AW];
      if (retire_we_i[w] && a != 0 && tmp[a] > 0) tmp[a]--;
    end
    for (int w = 0; w < WP; w++) begin
      a = issue_waddr_i[w*AW +: AW];
      if (issue_we_i[w] && a != 0) tmp[a]++;
    end
    for (int r = 0; r < RN; r++) if (tmp[r] > MAXP) ok = 1'b0;
    return rst_n ? ok : 1'b1;
  endfunction

  task automatic model_step();
    bit            ok;
    bit            st;
    logic [AW-1:0] a;
    st = exp_stall();
    ok = exp_ready();
    if (st) m_cnt = m_cnt + 32'd1;
    if (flush_i) begin
      for (int r = 0; r < RN; r++) m_pend[r] = 0;
    end else begin
      for (int w = 0; w < WP; w++) begin
        a = retire_waddr_i[w*AW +: AW];
        if (retire_we_i[w] && a != 0) begin
          if (m_pend[a] > 0) m_pend[a]--;
          else m_err = 1'b1;
        end
      end
      if (ok)
        for (int w = 0; w < WP; w++) begin
          a = issue_waddr_i[w*AW +: AW];
          if (issue_we_i[w] && a != 0) m_pend[a]++;
        end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    for (int p = 0; p < RP; p++) chk("cmp_rddata", rddata_o[p*32 +: 32], exp_rd(p));
    chk("cmp_stall", 32'(stall_o), 32'(exp_stall()));
    chk("cmp_issue_ready", 32'(issue_ready_o), 32'(exp_ready()));
    chk("cmp_err", 32'(err_o), 32'(m_err));
    chk("cmp_stall_cnt", stall_cnt_o, m_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    raddr_i        = '0;
    rddata_i       = {RP{32'h5A5A_5A5A}};
    fwd_we_i       = '0;
    fwd_waddr_i    = '0;
    fwd_wrdata_i   = '0;
    fwd_ready_i    = '0;
    issue_we_i     = '0;
    issue_waddr_i  = '0;
    retire_we_i    = '0;
    retire_waddr_i = '0;
    flush_i        = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    raddr_i[p*AW +: AW]  = AW'(a);
    rddata_i[p*32 +: 32] = 32'hA000_0000 + 32'(a);
  endtask

  task automatic set_fwd(input int s, input int w, input int a, input logic [31:0] d, input bit rdy);
    fwd_we_i[s*WP+w]                 = 1'b1;
    fwd_waddr_i[(s*WP+w)*AW +: AW]   = AW'(a);
    fwd_wrdata_i[(s*WP+w)*32 +: 32]  = d;
    fwd_ready_i[s*WP+w]              = rdy;
  endtask

  task automatic issue(input int w, input int a);
    issue_we_i[w]              = 1'b1;
    issue_waddr_i[w*AW +: AW]  = AW'(a);
  endtask

  task automatic retire(input int w, input int a);
    retire_we_i[w]              = 1'b1;
    retire_waddr_i[w*AW +: AW]  = AW'(a);
  endtask

  task automatic do_reset();
    clr();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    model_clear();
    clr();
    do_reset();

    // Youngest stage wins; within a stage the higher port wins.
    step(); clr();
    set_rd(0, 5);
    set_fwd(2, 0, 5, 32'h11, 1'b1);
    set_fwd(0, 1, 5, 32'h22, 1'b1);
    #1;
    chk("t1_young", rddata_o[31:0], 32'h22);
    chk("t1_nostall", 32'(stall_o), 32'd0);
    fwd_we_i[1] = 1'b0;
    #1;
    chk("t1_old", rddata_o[31:0], 32'h11);
    set_fwd(1, 0, 5, 32'h44, 1'b1);
    set_fwd(1, 1, 5, 32'h55, 1'b1);
    #1;
    chk("t1_hiport", rddata_o[31:0], 32'h55);
    fwd_we_i = '0;
    #1;
    chk("t1_regfile", rddata_o[31:0], 32'hA000_0005);

    // Younger not-ready match is not hidden by an older ready one.
    step(); clr();
    set_rd(1, 7);
    set_fwd(0, 0, 7, 32'h66, 1'b0);
    set_fwd(1, 0, 7, 32'h33, 1'b1);
    #1;
    chk("t2_stall", 32'(stall_o), 32'd1);
    step();
    fwd_ready_i[0] = 1'b1;
    #1;
    chk("t2_release", 32'(stall_o), 32'd0);
    chk("t2_data", rddata_o[63:32], 32'h66);

    // Long-latency producer: three stall cycles, counted.
    do_reset();
    issue(0, 9);
    #1;
    chk("t3_ready", 32'(issue_ready_o), 32'd1);
    step(); clr();
    set_rd(0, 9);
    #1;
    chk("t3_stall1", 32'(stall_o), 32'd1);
    step();
    #1;
    chk("t3_stall2", 32'(stall_o), 32'd1);
    step();
    retire(0, 9);
    #1;
    chk("t3_stall3", 32'(stall_o), 32'd1);
    step(); clr();
    set_rd(0, 9);
    #1;
    chk("t3_free", 32'(stall_o), 32'd0);
    chk("t3_cnt", stall_cnt_o, 32'd3);
    step();
    chk("t3_cnt_hold", stall_cnt_o, 32'd3);

    // Counter saturation and same-cycle retire credit.
    clr();
    for (int i = 0; i < 3; i++) begin
      issue(0, 4);
      #1;
      chk("t4_accept", 32'(issue_ready_o), 32'd1);
      step();
    end
    #1;
    chk("t4_full", 32'(issue_ready_o), 32'd0);
    retire(1, 4);
    #1;
    chk("t4_credit", 32'(issue_ready_o), 32'd1);
    step(); clr();
    issue(0, 4);
    set_rd(0, 4);
    #1;
    chk("t4_still_full", 32'(issue_ready_o), 32'd0);
    chk("t4_stall", 32'(stall_o), 32'd1);
    clr();
    retire(0, 4); retire(1, 4);
    step(); clr();
    retire(0, 4);
    step(); clr();
    set_rd(0, 4);
    #1;
    chk("t4_drained", 32'(stall_o), 32'd0);
    chk("t4_no_err", 32'(err_o), 32'd0);
    clr();
    issue(0, 11); issue(1, 11);
    #1;
    chk("t4_dual_ok", 32'(issue_ready_o), 32'd1);
    step();
    #1;
    chk("t4_dual_full", 32'(issue_ready_o), 32'd0);
    clr();
    retire(0, 11); retire(1, 11);
    step(); clr();

    // Underflow flag and register zero.
    retire(0, 6);
    #1;
    chk("t5_err_pre", 32'(err_o), 32'd0);
    step(); clr();
    #1;
    chk("t5_err", 32'(err_o), 32'd1);
    step();
    chk("t5_err_held", 32'(err_o), 32'd1);
    set_rd(0, 6);
    set_rd(1, 0);
    rddata_i[63:32] = 32'hFFFF_FFFF;
    set_fwd(0, 0, 0, 32'hFF, 1'b0);
    #1;
    chk("t5_r6_nostall", 32'(stall_o), 32'd0);
    chk("t5_r0_data", rddata_o[63:32], 32'd0);

    // Flush drops pending state and the flush-cycle issue.
    do_reset();
    issue(0, 3); issue(1, 3);
    step(); clr();
    issue(0, 8);
    step(); clr();
    set_rd(0, 3); set_rd(1, 8);
    #1;
    chk("t6_pre_stall", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    issue(0, 10);
    step(); clr();
    set_rd(0, 3); set_rd(1, 8); set_rd(2, 10);
    #1;
    chk("t6_flushed", 32'(stall_o), 32'd0);

    // Asynchronous reset in the middle of a stall.
    clr();
    issue(0, 12);
    step(); clr();
    set_rd(0, 12);
    #1;
    chk("t6_stall12", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(stall_o), 32'd0);
    chk("t6_rst_ready", 32'(issue_ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_post_rst", 32'(stall_o), 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
